// File: rtl/vga_timing_gen_if.sv
// Video timing bundle produced by vga_timing_gen and consumed by the pixel/rgb logic.
interface vga_timing_gen_if;
  logic       pixel_tick;
  logic [9:0] hCount;
  logic [9:0] vCount;
  logic       bright;
  logic       hSync;
  logic       vSync;
  logic       frame_start;
  logic [7:0] frame_count;

  modport master (
    output pixel_tick, hCount, vCount, bright, hSync, vSync, frame_start, frame_count
  );

  modport slave (
    input pixel_tick, hCount, vCount, bright, hSync, vSync, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60Hz VGA timing: pixel-rate divider, h/v counters, registered syncs/bright,
// and a per-frame pulse with an 8-bit frame counter.
module vga_timing_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [3:0] div_q,    div_d;
  logic       tick_q,   tick_d;
  logic [9:0] h_q,      h_d;
  logic [9:0] v_q,      v_d;
  logic       bright_q, bright_d;
  logic       hs_q,     hs_d;
  logic       vs_q,     vs_d;
  logic       fs_q,     fs_d;
  logic [7:0] fc_q,     fc_d;

  // Next-state: divider every clk; counters and the flags derived from them only on a pixel tick.
  always_comb begin
    div_d    = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
    tick_d   = (div_d == DIV_LAST);
    h_d      = h_q;
    v_d      = v_q;
    bright_d = bright_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    fs_d     = 1'b0;
    fc_d     = fc_q;
    if (tick_q) begin
      if (h_q == H_LAST) begin
        h_d = 10'd0;
        if (v_q == V_LAST) begin
          v_d = 10'd0;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
      end
      // Flags use the next counter values so they land on the same edge as the counters.
      bright_d = (h_d < H_VIS) && (v_d < V_VIS);
      hs_d     = ((h_d >= HS_FIRST) && (h_d <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
      vs_d     = ((v_d >= VS_FIRST) && (v_d <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
      if ((h_d == 10'd0) && (v_d == 10'd0)) begin
        fs_d = 1'b1;
        fc_d = fc_q + 8'd1;
      end else begin
        fs_d = 1'b0;
      end
    end else begin
      fs_d = 1'b0;
    end
  end

  // State registers with asynchronous return to the top-left, pre-first-pixel state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q    <= 4'd0;
      tick_q   <= 1'b0;
      h_q      <= 10'd0;
      v_q      <= 10'd0;
      bright_q <= 1'b0;
      hs_q     <= ~SYNC_POL;
      vs_q     <= ~SYNC_POL;
      fs_q     <= 1'b0;
      fc_q     <= 8'd0;
    end else begin
      div_q    <= div_d;
      tick_q   <= tick_d;
      h_q      <= h_d;
      v_q      <= v_d;
      bright_q <= bright_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      fs_q     <= fs_d;
      fc_q     <= fc_d;
    end
  end

  assign vga.pixel_tick  = tick_q;
  assign vga.hCount      = h_q;
  assign vga.vCount      = v_q;
  assign vga.bright      = bright_q;
  assign vga.hSync       = hs_q;
  assign vga.vSync       = vs_q;
  assign vga.frame_start = fs_q;
  assign vga.frame_count = fc_q;

endmodule
